flip_column_dispatcher: RTL and testbench

- Producer side of the compute_unit column interface.
- Takes sigma_old/sigma_new, derives the flip mask, and issues flipped column indices up to COL_PER_CC per cycle. Each issued column carries its lane valid, sigma_c bit and final flag.
- Drives the accumulator clear pulse before each run.
- Sits between the spin-update controller and the J-column fetch / compute_unit lanes.

---
 rtl/ising_dispatch_pkg.sv | 17 +
 rtl/lowest_n_picker.sv | 36 +++
 rtl/flip_column_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_flip_column_dispatcher.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_dispatch_pkg.sv
// Shared defaults, index type and FSM state encoding for the flip column dispatcher.
package ising_dispatch_pkg;

    localparam int VECTOR_SIZE = 256;
    localparam int COL_PER_CC  = 4;
    localparam int IDX_W       = $clog2(VECTOR_SIZE);

    typedef logic [IDX_W-1:0] col_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DONE
    } dispatch_state_t;

endpackage

// File: rtl/lowest_n_picker.sv
// Combinational selector of the COL_PER_CC lowest set bits of a mask, packed into lanes
// in ascending index order, together with the mask left over after removing them.
module lowest_n_picker #(
    parameter int VECTOR_SIZE = ising_dispatch_pkg::VECTOR_SIZE,
    parameter int COL_PER_CC  = ising_dispatch_pkg::COL_PER_CC,
    parameter int IDX_W       = $clog2(VECTOR_SIZE)
) (
    input  logic [VECTOR_SIZE-1:0]      mask,
    output logic [COL_PER_CC*IDX_W-1:0] idx,
    output logic [COL_PER_CC-1:0]       hit,
    output logic [VECTOR_SIZE-1:0]      remaining
);

    logic [VECTOR_SIZE-1:0] rem;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        rem = mask;
        idx = '0;
        hit = '0;
        for (int k = 0; k < COL_PER_CC; k++) begin
            // Scanning downward lets the lowest set bit win the last assignment.
            for (int b = VECTOR_SIZE - 1; b >= 0; b--) begin
                if (rem[b]) begin
                    idx[k*IDX_W +: IDX_W] = IDX_W'(b);
                    hit[k]                = 1'b1;
                end
            end
            if (hit[k]) begin
                rem[idx[k*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        remaining = rem;
    end

endmodule

// File: rtl/flip_column_dispatcher.sv
// Issues the columns flipped between sigma_old and sigma_new, COL_PER_CC lanes per beat,
// preceded by an accumulator clear pulse. Optional counters: define DISPATCH_STATS_EN.
module flip_column_dispatcher #(
    parameter int VECTOR_SIZE = ising_dispatch_pkg::VECTOR_SIZE,
    parameter int COL_PER_CC  = ising_dispatch_pkg::COL_PER_CC,
    parameter int IDX_W       = $clog2(VECTOR_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [VECTOR_SIZE-1:0]      sigma_old_i,
    input  logic [VECTOR_SIZE-1:0]      sigma_new_i,
    input  logic                        hold_i,
    output logic                        clear_o,
    output logic [COL_PER_CC-1:0]       valid_o,
    output logic [COL_PER_CC-1:0]       final_flag_o,
    output logic [COL_PER_CC*IDX_W-1:0] col_idx_o,
    output logic [COL_PER_CC-1:0]       sigma_c_o,
    output logic                        busy_o,
    output logic                        done_o
`ifdef DISPATCH_STATS_EN
    ,
    output logic [IDX_W:0]              flip_count_o,
    output logic [IDX_W:0]              beat_count_o
`endif
);

    import ising_dispatch_pkg::*;

    dispatch_state_t state, state_d;

    logic [VECTOR_SIZE-1:0]      mask, mask_d;
    logic [VECTOR_SIZE-1:0]      sig_new, sig_new_d;
    logic                        clear_d, busy_d, done_d;
    logic [COL_PER_CC-1:0]       valid_d, final_d, sigma_c_d;
    logic [COL_PER_CC*IDX_W-1:0] col_idx_d;

    logic [COL_PER_CC*IDX_W-1:0] pick_idx;
    logic [COL_PER_CC-1:0]       pick_hit;
    logic [VECTOR_SIZE-1:0]      pick_rem;

    lowest_n_picker #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .COL_PER_CC  (COL_PER_CC),
        .IDX_W       (IDX_W)
    ) u_picker (
        .mask      (mask),
        .idx       (pick_idx),
        .hit       (pick_hit),
        .remaining (pick_rem)
    );

    // Outputs are recomputed here and registered below; holding simply re-registers them.
    always_comb begin
        state_d   = state;
        mask_d    = mask;
        sig_new_d = sig_new;
        clear_d   = clear_o;
        valid_d   = valid_o;
        final_d   = final_flag_o;
        col_idx_d = col_idx_o;
        sigma_c_d = sigma_c_o;
        busy_d    = busy_o;
        done_d    = done_o;

        case (state)
            IDLE: begin
                clear_d   = 1'b0;
                valid_d   = '0;
                final_d   = '0;
                col_idx_d = '0;
                sigma_c_d = '0;
                done_d    = 1'b0;
                busy_d    = 1'b0;
                // The done_o cycle still belongs to the previous run.
                if (start_i && !done_o) begin
                    state_d   = CLEAR;
                    mask_d    = sigma_old_i ^ sigma_new_i;
                    sig_new_d = sigma_new_i;
                    busy_d    = 1'b1;
                end
            end
            CLEAR: begin
                clear_d = 1'b1;
                if (!hold_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (!hold_i) begin
                    clear_d   = 1'b0;
                    valid_d   = pick_hit;
                    col_idx_d = pick_idx;
                    mask_d    = pick_rem;
                    for (int k = 0; k < COL_PER_CC; k++) begin
                        sigma_c_d[k] = pick_hit[k] & sig_new[pick_idx[k*IDX_W +: IDX_W]];
                    end
                    final_d = '0;
                    if (pick_rem == '0) begin
                        // A run with no flips still ends with a single flagged beat on lane 0.
                        final_d = (pick_hit == '0) ? COL_PER_CC'(1) : pick_hit;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valid_d   = '0;
                final_d   = '0;
                col_idx_d = '0;
                sigma_c_d = '0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the combinational block uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mask         <= '0;
            sig_new      <= '0;
            clear_o      <= 1'b0;
            valid_o      <= '0;
            final_flag_o <= '0;
            col_idx_o    <= '0;
            sigma_c_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_d;
            mask         <= mask_d;
            sig_new      <= sig_new_d;
            clear_o      <= clear_d;
            valid_o      <= valid_d;
            final_flag_o <= final_d;
            col_idx_o    <= col_idx_d;
            sigma_c_o    <= sigma_c_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [IDX_W:0] mask_pop;

    always_comb begin
        mask_pop = '0;
        for (int b = 0; b < VECTOR_SIZE; b++) begin
            mask_pop = mask_pop + (IDX_W + 1)'(mask[b]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip_count_o <= '0;
            beat_count_o <= '0;
        end else begin
            if (state == IDLE && start_i && !done_o) beat_count_o <= '0;
            if (state == CLEAR) flip_count_o <= mask_pop;
            if (state == ISSUE && !hold_i) beat_count_o <= beat_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_flip_column_dispatcher.sv
// Randomized and directed bench for flip_column_dispatcher against a queue-based reference model.
module tb_flip_column_dispatcher;

    import ising_dispatch_pkg::*;

    localparam int VS = VECTOR_SIZE;
    localparam int NC = COL_PER_CC;
    localparam int IW = IDX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [VS-1:0]     sigma_old_i;
    logic [VS-1:0]     sigma_new_i;
    logic              hold_i;
    logic              clear_o;
    logic [NC-1:0]     valid_o;
    logic [NC-1:0]     final_flag_o;
    logic [NC*IW-1:0]  col_idx_o;
    logic [NC-1:0]     sigma_c_o;
    logic              busy_o;
    logic              done_o;
`ifdef DISPATCH_STATS_EN
    logic [IW:0]       flip_count_o;
    logic [IW:0]       beat_count_o;
`endif

    flip_column_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .sigma_old_i  (sigma_old_i),
        .sigma_new_i  (sigma_new_i),
        .hold_i       (hold_i),
        .clear_o      (clear_o),
        .valid_o      (valid_o),
        .final_flag_o (final_flag_o),
        .col_idx_o    (col_idx_o),
        .sigma_c_o    (sigma_c_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef DISPATCH_STATS_EN
        ,
        .flip_count_o (flip_count_o),
        .beat_count_o (beat_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a run is a queue of flipped indices drained NC at a time.
    typedef enum {P_IDLE, P_CLEAR, P_ISSUE, P_DONE} phase_t;
    phase_t        m_phase = P_IDLE;
    int            q[$];
    logic [VS-1:0] m_sig;
    int            m_flips;
    logic          exp_clear, exp_busy, exp_done;
    logic [NC-1:0] exp_valid, exp_final, exp_sigc;
    logic [NC*IW-1:0] exp_idx;
    int            exp_flip_cnt, exp_beat_cnt;

    task automatic model_reset();
        m_phase = P_IDLE;
        q.delete();
        m_sig = '0;
        exp_clear = 0; exp_busy = 0; exp_done = 0;
        exp_valid = '0; exp_final = '0; exp_sigc = '0; exp_idx = '0;
        exp_flip_cnt = 0; exp_beat_cnt = 0;
    endtask

    task automatic zero_lanes();
        exp_valid = '0; exp_final = '0; exp_sigc = '0; exp_idx = '0;
    endtask

    task automatic model_edge(input logic st, input logic hd);
        case (m_phase)
            P_IDLE: begin
                bit accept;
                zero_lanes();
                exp_clear = 0;
                accept    = st && !exp_done;
                exp_done  = 0;
                exp_busy  = accept;
                if (accept) begin
                    q.delete();
                    for (int b = 0; b < VS; b++) if (sigma_old_i[b] != sigma_new_i[b]) q.push_back(b);
                    m_sig        = sigma_new_i;
                    m_flips      = q.size();
                    exp_beat_cnt = 0;
                    m_phase      = P_CLEAR;
                end
            end
            P_CLEAR: begin
                exp_clear    = 1;
                exp_flip_cnt = m_flips;
                if (!hd) m_phase = P_ISSUE;
            end
            P_ISSUE: begin
                if (!hd) begin
                    exp_clear = 0;
                    zero_lanes();
                    for (int k = 0; k < NC; k++) begin
                        if (q.size() > 0) begin
                            int b;
                            b = q.pop_front();
                            exp_valid[k] = 1'b1;
                            exp_idx[k*IW +: IW] = IW'(b);
                            exp_sigc[k] = m_sig[b];
                        end
                    end
                    exp_beat_cnt++;
                    if (q.size() == 0) begin
                        exp_final = (exp_valid == '0) ? NC'(1) : exp_valid;
                        m_phase = P_DONE;
                    end
                end
            end
            P_DONE: begin
                zero_lanes();
                exp_done = 1;
                m_phase  = P_IDLE;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("clear_o",      clear_o,      exp_clear);
            check("valid_o",      valid_o,      exp_valid);
            check("final_flag_o", final_flag_o, exp_final);
            check("col_idx_o",    col_idx_o,    exp_idx);
            check("sigma_c_o",    sigma_c_o,    exp_sigc);
            check("busy_o",       busy_o,       exp_busy);
            check("done_o",       done_o,       exp_done);
`ifdef DISPATCH_STATS_EN
            check("flip_count_o", flip_count_o, exp_flip_cnt);
            check("beat_count_o", beat_count_o, exp_beat_cnt);
`endif
        end
    end

    // One clock: inputs driven after the previous edge, model advanced at this edge.
    task automatic step(input logic st, input logic hd);
        start_i = st;
        hold_i  = hd;
        @(posedge clk);
        model_edge(st, hd);
        #1;
    endtask

    function automatic logic [VS-1:0] rand_vec();
        logic [VS-1:0] v;
        for (int w = 0; w < VS / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic drain(input bit rand_ctl);
        int guard = 0;
        while ((m_phase != P_IDLE || exp_done || exp_busy) && guard < 400) begin
            step(rand_ctl && ($urandom_range(0, 2) == 0), rand_ctl && ($urandom_range(0, 3) == 0));
            guard++;
        end
        check("drain_bound", guard < 400, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_clear"}, clear_o, 0);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_final"}, final_flag_o, 0);
        check({tag, "_idx"},   col_idx_o, 0);
        check({tag, "_sigc"},  sigma_c_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
    endtask

    initial begin
        logic [VS-1:0] base, fm;
        col_idx_t      lane_idx;

        rst = 1'b1; start_i = 0; hold_i = 0;
        sigma_old_i = '0; sigma_new_i = '0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        #11 rst = 1'b0;
        @(posedge clk); #1;
        cmp_en = 1'b1;

        // Zero flips: one empty beat flagged on lane 0.
        base = rand_vec();
        sigma_old_i = base; sigma_new_i = base;
        step(1, 0);
        step(0, 0); check("zf_clear", clear_o, 1);
        step(0, 0); check("zf_valid", valid_o, 4'b0000); check("zf_final", final_flag_o, 4'b0001);
        check("zf_clear_low", clear_o, 0);
        step(0, 0); check("zf_done", done_o, 1); check("zf_busy", busy_o, 1);
        step(0, 0); check("zf_idle_busy", busy_o, 0); check("zf_done_low", done_o, 0);

        // Single flip at the top bit.
        base = rand_vec();
        base[255] = 1'b0;
        sigma_old_i = base; sigma_new_i = base; sigma_new_i[255] = 1'b1;
        step(1, 0); step(0, 0); step(0, 0);
        check("one_valid", valid_o, 4'b0001);
        lane_idx = col_idx_o[IW-1:0];
        check("one_idx", lane_idx, 255);
        check("one_sigc", sigma_c_o, 4'b0001);
        check("one_final", final_flag_o, 4'b0001);
        step(0, 0); check("one_done", done_o, 1);
        drain(0);

        // Five flips with a three-cycle stall before the second beat.
        base = rand_vec();
        fm = '0; fm[3] = 1; fm[7] = 1; fm[64] = 1; fm[128] = 1; fm[200] = 1;
        sigma_old_i = base; sigma_new_i = base ^ fm;
        step(1, 0); step(0, 0); step(0, 0);
        check("five_b1_valid", valid_o, 4'b1111);
        check("five_b1_idx", col_idx_o, {8'd128, 8'd64, 8'd7, 8'd3});
        check("five_b1_final", final_flag_o, 4'b0000);
        repeat (3) begin
            step(0, 1);
            check("five_hold_valid", valid_o, 4'b1111);
            check("five_hold_done", done_o, 0);
        end
        step(0, 0);
        check("five_b2_valid", valid_o, 4'b0001);
        lane_idx = col_idx_o[IW-1:0];
        check("five_b2_idx", lane_idx, 200);
        check("five_b2_final", final_flag_o, 4'b0001);
        step(0, 0); check("five_done", done_o, 1);
        drain(0);

        // Every spin flipped: 64 full beats in ascending order.
        base = rand_vec();
        sigma_old_i = base; sigma_new_i = ~base;
        step(1, 0); step(0, 0);
        for (int j = 0; j < VS / NC; j++) begin
            step(0, 0);
            check("all_valid", valid_o, 4'b1111);
            check("all_idx", col_idx_o, {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
            check("all_final", final_flag_o, (j == VS / NC - 1) ? 4'b1111 : 4'b0000);
        end
        step(0, 0); check("all_done", done_o, 1);
`ifdef DISPATCH_STATS_EN
        check("all_flip_count", flip_count_o, 256);
        check("all_beat_count", beat_count_o, 64);
`endif
        drain(0);

        // Reset in the middle of an all-flipped run, then a clean restart.
        step(1, 0);
        repeat (5) step(0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1 check_zero_outputs("midrst");
        @(posedge clk); #1;
        check_zero_outputs("midrst_hold");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        step(1, 0); step(0, 0); step(0, 0);
        check("restart_idx", col_idx_o, {8'd3, 8'd2, 8'd1, 8'd0});
        check("restart_valid", valid_o, 4'b1111);
        drain(0);

        // Randomized runs with random stalls, stray starts and changing inputs.
        for (int r = 0; r < 40; r++) begin
            int mode;
            mode = $urandom_range(0, 3);
            fm = '0;
            case (mode)
                1: repeat ($urandom_range(1, 9)) fm[$urandom_range(0, VS - 1)] = 1'b1;
                2: fm = rand_vec();
                3: fm = rand_vec() & rand_vec() & rand_vec();
                default: fm = '0;
            endcase
            base = rand_vec();
            sigma_old_i = base; sigma_new_i = base ^ fm;
            step(1, ($urandom_range(0, 3) == 0));
            sigma_old_i = rand_vec(); sigma_new_i = rand_vec();
            drain(1);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
